// File: rtl/spi_chnl_scanner_pkg.sv
// Shared types and constants for the SPI A2D channel scanner.
package spi_chnl_scanner_pkg;

    // Sequencer states, in the order they are visited for one channel.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WAIT1 = 3'd2,
        GAP   = 3'd3,
        RD    = 3'd4,
        WAIT2 = 3'd5,
        STORE = 3'd6
    } scan_state_t;

    localparam int          RES_W    = 12;       // A2D result width
    localparam int          CH_W     = 3;        // channel field width in the command frame
    localparam logic [1:0]  CMD_HDR  = 2'b00;    // top bits of a command frame
    localparam logic [15:0] RD_FRAME = 16'h0000; // frame that clocks the result back

    // Command frame selecting channel ch: {hdr, ch, 11 zero bits}.
    function automatic logic [15:0] cmd_frame(input logic [CH_W-1:0] ch);
        return {CMD_HDR, ch, 11'h000};
    endfunction

endpackage

// File: rtl/spi_chnl_scanner_if.sv
// Scanner <-> SPI master bus.
// Handshake: spi_wrt is a single-cycle start pulse that launches one 16-bit
// frame carrying spi_cmd (valid while spi_wrt is high). spi_done is a level
// driven by the SPI master: it drops when a frame is started and rises when
// the frame is finished, at which point spi_rd_data holds the returned word.
// Only the rising edge of spi_done marks completion.
interface spi_chnl_scanner_if;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;

    modport master (
        output spi_wrt,
        output spi_cmd,
        input  spi_done,
        input  spi_rd_data
    );

    modport slave (
        input  spi_wrt,
        input  spi_cmd,
        output spi_done,
        output spi_rd_data
    );
endinterface

// File: rtl/spi_chnl_scanner_wdog.sv
// Loadable up-counter with a terminal-count flag; shared by the inter-frame
// gap timer and the per-frame watchdog.
module scan_wdog #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    // Clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == i_tc_val);
endmodule

// File: rtl/spi_chnl_scanner.sv
// Round-robin A2D scanner: command frame, gap, read frame, store, next channel.
module spi_chnl_scanner
    import spi_chnl_scanner_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int GAP_CYC = 8,
    parameter int TO_CYC  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [CH_W-1:0]    i_rd_ch,
    output logic [RES_W-1:0]   o_rd_val,
    output logic [NUM_CH-1:0]  o_res_vld,
    output logic               o_scan_done,
    output logic               o_err,
    output scan_state_t        o_state,
    spi_chnl_scanner_if.master io_spi
);
    localparam int CNT_W = $clog2((TO_CYC > GAP_CYC) ? TO_CYC : GAP_CYC) + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    scan_state_t      r_state;
    scan_state_t      w_next;
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  w_ch_inc;
    logic [CH_W-1:0]  w_cmd_ch;
    logic [15:0]      r_spi_cmd;
    logic [RES_W-1:0] r_results [NUM_CH];
    logic [NUM_CH-1:0] r_res_vld;
    logic             r_err;
    logic             r_done_q;
    logic             w_done_rise;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cnt_tc;
    logic [CNT_W-1:0] w_tc_val;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_unused_rd_hi;

    // A stale high level of spi_done is not a completion; only a new rise is.
    assign w_done_rise = io_spi.spi_done & ~r_done_q;
    assign w_waiting   = (r_state == WAIT1) || (r_state == WAIT2);
    assign w_timeout   = w_waiting && !w_done_rise && w_cnt_tc;
    assign w_tc_val    = (r_state == GAP) ? CNT_W'(GAP_CYC - 1) : CNT_W'(TO_CYC - 1);
    assign w_ch_inc    = (r_ch == LAST_CH) ? '0 : r_ch + CH_W'(1);
    // Leaving STORE the command goes out for the channel after the one stored.
    assign w_cmd_ch    = (r_state == STORE) ? w_ch_inc : r_ch;
    assign w_unused_rd_hi = ^io_spi.spi_rd_data[15:RES_W];

    scan_wdog #(.W(CNT_W)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_cnt_inc),
        .i_tc_val (w_tc_val),
        .o_tc     (w_cnt_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a done rise wins over a same-cycle watchdog expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_en && !r_err) w_next = CMD;
            CMD:     w_next = WAIT1;
            WAIT1:   if (w_done_rise) w_next = GAP;
                     else if (w_cnt_tc) w_next = IDLE;
            GAP:     if (w_cnt_tc) w_next = RD;
            RD:      w_next = WAIT2;
            WAIT2:   if (w_done_rise) w_next = STORE;
                     else if (w_cnt_tc) w_next = IDLE;
            STORE:   w_next = i_en ? CMD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-state outputs: start pulse, counter control, scan-complete pulse.
    always_comb begin
        io_spi.spi_wrt = (r_state == CMD) || (r_state == RD);
        w_cnt_clr      = (r_state == CMD) || (r_state == RD) ||
                         ((r_state == WAIT1) && w_done_rise);
        w_cnt_inc      = w_waiting || (r_state == GAP);
        o_scan_done    = (r_state == STORE) && (r_ch == LAST_CH);
    end

    // Datapath: done edge history, frame register, sticky error, result file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q  <= 1'b0;
            r_ch      <= '0;
            r_spi_cmd <= '0;
            r_res_vld <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_results[i] <= '0;
            end
        end else begin
            r_done_q <= io_spi.spi_done;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_next == CMD) begin
                r_spi_cmd <= cmd_frame(w_cmd_ch);
            end else if (w_next == RD) begin
                r_spi_cmd <= RD_FRAME;
            end
            if (r_state == STORE) begin
                r_results[r_ch] <= io_spi.spi_rd_data[RES_W-1:0];
                r_res_vld[r_ch] <= 1'b1;
                r_ch            <= w_ch_inc;
            end
        end
    end

    // Host read port; channels beyond the scanned range read as zero.
    always_comb begin
        o_rd_val = '0;
        if (int'(i_rd_ch) < NUM_CH) begin
            o_rd_val = r_results[i_rd_ch];
        end
    end

    assign io_spi.spi_cmd = r_spi_cmd;
    assign o_res_vld      = r_res_vld;
    assign o_err          = r_err;
    assign o_state        = r_state;
endmodule

// File: tb/tb_spi_chnl_scanner.sv
// Self-checking bench for spi_chnl_scanner with a behavioural SPI/A2D slave.
module tb_spi_chnl_scanner;
    import spi_chnl_scanner_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int GAP_CYC   = 8;
    localparam int TO_CYC    = 1024;
    localparam int FRAME_CYC = 5;
    localparam int STALE_CYC = 4;
    localparam int NONE      = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [2:0]  rd_ch = 3'd0;
    logic [11:0] rd_val;
    logic [7:0]  res_vld;
    logic        scan_done;
    logic        err;
    scan_state_t state;
    int          cyc = 0;

    spi_chnl_scanner_if spi_bus ();

    spi_chnl_scanner #(
        .NUM_CH  (NUM_CH),
        .GAP_CYC (GAP_CYC),
        .TO_CYC  (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .i_rd_ch     (rd_ch),
        .o_rd_val    (rd_val),
        .o_res_vld   (res_vld),
        .o_scan_done (scan_done),
        .o_err       (err),
        .o_state     (state),
        .io_spi      (spi_bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int          n_tests  = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];          // {is_read_frame, frame}
    logic [11:0] exp_res [NUM_CH];
    logic [7:0]  exp_vld  = 8'h00;
    logic [11:0] base     = 12'h000;
    int          hang_ch  = NONE;
    int          stale_ch = NONE;
    int          scan_cnt = 0;
    int          rise_cyc = 0;
    int          last_wrt_cyc = 0;
    logic        prev_wrt = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- SPI master / A2D slave model ----------------
    logic        s_busy = 1'b0;
    logic        s_expect_cmd = 1'b1;
    logic        s_hang = 1'b0;
    logic        s_stale = 1'b0;
    int          s_cnt = 0;
    int          s_lim = 0;
    logic [2:0]  s_ch = 3'd0;
    logic [15:0] s_data = 16'h0000;

    always @(negedge clk) begin
        if (rst) begin
            s_busy = 1'b0;
            s_expect_cmd = 1'b1;
            spi_bus.spi_done = 1'b0;
            spi_bus.spi_rd_data = 16'h0000;
        end else if (spi_bus.spi_wrt) begin
            s_hang  = 1'b0;
            s_stale = 1'b0;
            if (s_expect_cmd) begin
                s_ch = spi_bus.spi_cmd[13:11];
                s_expect_cmd = 1'b0;
                s_hang  = (int'(s_ch) == hang_ch);
                s_stale = (int'(s_ch) == stale_ch);
                s_data  = 16'hF000;
            end else begin
                s_expect_cmd = 1'b1;
                s_data = {4'hA, base + 12'(s_ch)};
            end
            s_cnt  = 0;
            s_busy = 1'b1;
            s_lim  = s_stale ? FRAME_CYC + STALE_CYC : FRAME_CYC;
            if (!s_stale) spi_bus.spi_done = 1'b0;
        end else if (s_busy) begin
            s_cnt++;
            if (s_stale && s_cnt == STALE_CYC) spi_bus.spi_done = 1'b0;
            if (s_cnt == s_lim) begin
                s_busy = 1'b0;
                if (!s_hang) begin
                    spi_bus.spi_rd_data = s_data;
                    spi_bus.spi_done = 1'b1;
                    rise_cyc = cyc;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            if (scan_done) scan_cnt++;
            if (spi_bus.spi_wrt) begin
                check("wrt_single_cycle", 32'(prev_wrt), 32'd0);
                last_wrt_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wrt: got frame 0x%h expected no frame", spi_bus.spi_cmd);
                end else begin
                    e = exp_q.pop_front();
                    check("spi_cmd", 32'(spi_bus.spi_cmd), 32'(e[15:0]));
                    if (e[16]) check("gap_cycles", 32'(cyc - rise_cyc), 32'(GAP_CYC + 1));
                end
            end
        end
        prev_wrt = spi_bus.spi_wrt;
    end

    // ---------------- driver tasks ----------------
    task automatic push_chan(input int ch, input bit with_rd, input bit store);
        logic [15:0] f;
        f = 16'(ch) << 11;
        exp_q.push_back({1'b0, f});
        if (with_rd) exp_q.push_back({1'b1, 16'h0000});
        if (store) begin
            exp_res[ch] = base + 12'(ch);
            exp_vld[ch] = 1'b1;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_CH; i++) exp_res[i] = 12'h000;
        exp_vld = 8'h00;
    endtask

    task automatic wait_q_left(input int left, input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != left; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'(left));
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && !(state == IDLE && exp_q.size() == 0); i++) @(negedge clk);
        check(name, 32'(state), 32'(IDLE));
    endtask

    task automatic check_results(input string name);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rd_ch = 3'(ch);
            #1;
            check($sformatf("%s_rd%0d", name, ch), 32'(rd_val), 32'(exp_res[ch]));
        end
        check({name, "_res_vld"}, 32'(res_vld), 32'(exp_vld));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int err_cyc;
        clear_model();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_spi_wrt",   32'(spi_bus.spi_wrt), 32'd0);
        check("rst_spi_cmd",   32'(spi_bus.spi_cmd), 32'd0);
        check("rst_err",       32'(err), 32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        check("rst_state",     32'(state), 32'(IDLE));
        check_results("rst");

        // Full scan of all channels, slave returns 0x100+ch
        base = 12'h100;
        for (int ch = 0; ch < NUM_CH; ch++) push_chan(ch, 1'b1, 1'b1);
        en = 1'b1;
        wait_q_left(0, 600, "scan1_frames");
        en = 1'b0;
        wait_idle(100, "scan1_idle");
        check("scan1_done_pulses", 32'(scan_cnt), 32'd1);
        check_results("scan1");
        rd_ch = 3'd5;
        #1;
        check("scan1_rd5", 32'(rd_val), 32'h105);

        // Drop en during WAIT1 of ch 3: ch 3 still completes
        base = 12'h200;
        for (int ch = 0; ch < 4; ch++) push_chan(ch, 1'b1, 1'b1);
        en = 1'b1;
        wait_q_left(1, 300, "drop_cmd3");
        @(negedge clk);
        en = 1'b0;
        wait_idle(100, "drop_idle");
        check_results("drop");
        check("drop_done_pulses", 32'(scan_cnt), 32'd1);

        // Resume at ch 4; ch 5 command sees a stale spi_done level
        base = 12'h300;
        stale_ch = 5;
        for (int ch = 4; ch < NUM_CH; ch++) push_chan(ch, 1'b1, 1'b1);
        en = 1'b1;
        wait_q_left(0, 400, "resume_frames");
        en = 1'b0;
        wait_idle(100, "resume_idle");
        stale_ch = NONE;
        check("resume_done_pulses", 32'(scan_cnt), 32'd2);
        check_results("resume");

        // Watchdog: slave never finishes ch 2 command frame
        base = 12'h400;
        hang_ch = 2;
        push_chan(0, 1'b1, 1'b1);
        push_chan(1, 1'b1, 1'b1);
        push_chan(2, 1'b0, 1'b0);
        en = 1'b1;
        wait_q_left(0, 300, "to_frames");
        for (int i = 0; i < TO_CYC + 100 && !err; i++) @(negedge clk);
        err_cyc = cyc;
        check("to_err_set", 32'(err), 32'd1);
        check("to_err_latency", 32'(err_cyc - last_wrt_cyc), 32'(TO_CYC + 1));
        repeat (40) @(negedge clk);
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_state_idle", 32'(state), 32'(IDLE));
        check_results("to");
        hang_ch = NONE;
        en = 1'b0;

        // Reset clears err
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_model();
        check("rst2_err_clear", 32'(err), 32'd0);

        // Reset mid-WAIT2 of ch 6
        base = 12'h500;
        for (int ch = 0; ch < 6; ch++) push_chan(ch, 1'b1, 1'b1);
        push_chan(6, 1'b1, 1'b0);
        en = 1'b1;
        wait_q_left(0, 500, "mid_frames");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_model();
        check("mid_rst_state",     32'(state), 32'(IDLE));
        check("mid_rst_spi_wrt",   32'(spi_bus.spi_wrt), 32'd0);
        check("mid_rst_spi_cmd",   32'(spi_bus.spi_cmd), 32'd0);
        check("mid_rst_err",       32'(err), 32'd0);
        check("mid_rst_scan_done", 32'(scan_done), 32'd0);
        check_results("mid_rst");

        // Restart resumes at ch 0
        base = 12'h600;
        push_chan(0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        wait_q_left(0, 100, "restart_frames");
        en = 1'b0;
        wait_idle(100, "restart_idle");
        check_results("restart");
        check("final_done_pulses", 32'(scan_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no end of test expected end before 1ms");
        $fatal(1);
    end
endmodule
